// File: rtl/synth_frame_trig_gen_pkg.sv
// ---------------------------------------------------------------------------
// synth_frame_trig_gen_pkg / utils
//
// Purpose:
//   utils                    : generic elaboration-time helpers shared across
//                              the codebase (clogb2 for width derivation).
//   synth_frame_trig_gen_pkg : default rates and widths for the synth frame
//                              trigger generator and its rate divider.
//
// Ports: none (packages only).
// ---------------------------------------------------------------------------
package utils;

    // Number of bits needed to hold values 0..value-1, i.e. ceil(log2(value)).
    // Returns 0 for value <= 1.
    function automatic int clogb2(input longint unsigned value);
        longint unsigned v;
        int              bits;
        v    = (value > 0) ? value - 1 : 0;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage

package synth_frame_trig_gen_pkg;

    localparam int unsigned DEF_AUDIO_CLK_RATE = 90416666;
    localparam int unsigned DEF_SAMPLE_RATE    = 44100;
    localparam int unsigned DEF_TRIG_HIGH      = 4;
    localparam int unsigned DEF_FRAME_CNT_W    = 16;
    localparam int unsigned DEF_OVR_CNT_W      = 8;

endpackage

// File: rtl/synth_frame_trig_gen_frac_rate_div.sv
// ---------------------------------------------------------------------------
// frac_rate_div
//
// Purpose:
//   Fractional-N phase accumulator. Adds INC every enabled clock and wraps
//   modulo MOD, producing exactly INC ticks per MOD enabled cycles with at
//   most one cycle of period jitter. Reusable for any rate derivation where
//   INC < MOD.
//
// Ports:
//   AUDIO_CLK    in   clock
//   reset_reg_N  in   asynchronous, active-low reset
//   enable_i     in   0 = accumulator held at 0, no ticks
//   tick_o       out  combinational: this edge wraps the accumulator
// ---------------------------------------------------------------------------
module frac_rate_div
    import synth_frame_trig_gen_pkg::*;
#(
    parameter int unsigned MOD = 10,
    parameter int unsigned INC = 3
) (
    input  logic AUDIO_CLK,
    input  logic reset_reg_N,
    input  logic enable_i,
    output logic tick_o
);

    // One extra bit over what MOD needs so acc + INC (< 2*MOD) never overflows.
    localparam int ACC_W = utils::clogb2(MOD) + 1;

    localparam logic [ACC_W-1:0] MOD_V = ACC_W'(MOD);
    localparam logic [ACC_W-1:0] INC_V = ACC_W'(INC);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] accSum;
    logic             tick;

    // Next phase: add the increment, subtract the modulus on wrap. The wrap
    // itself is the tick, so callers register it on the same edge.
    always_comb begin
        accSum = acc_q + INC_V;
        tick   = 1'b0;
        acc_d  = accSum;
        if (!enable_i) begin
            acc_d = '0;
        end else if (accSum >= MOD_V) begin
            acc_d = accSum - MOD_V;
            tick  = 1'b1;
        end
    end

    // Phase register.
    always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign tick_o = tick;

endmodule

// File: rtl/synth_frame_trig_gen.sv
// ---------------------------------------------------------------------------
// synth_frame_trig_gen
//
// Purpose:
//   Generates the per-sample trigger that launches one synth frame in
//   synth_clk_gen. A fractional-N divider derives SAMPLE_RATE from
//   AUDIO_CLK exactly over the long term; each tick becomes a trig pulse
//   TRIG_HIGH cycles wide so the downstream 2-flop synchroniser always sees
//   it. A frame coming due while 'run' is still high is flagged as overrun.
//
// Ports:
//   AUDIO_CLK     in   clock
//   reset_reg_N   in   asynchronous, active-low reset
//   enable        in   0 = divider held at 0, no frames, frame_cnt cleared
//   run           in   synth_clk_gen frame in progress
//   overrun_clr   in   1-cycle pulse clearing overrun and overrun_cnt
//   trig          out  frame trigger, TRIG_HIGH cycles wide
//   frame_strobe  out  1-cycle pulse on the first trig-high cycle
//   frame_cnt     out  frames issued since reset/enable rise (wraps)
//   overrun       out  sticky overrun flag
//   overrun_cnt   out  saturating overrun count
// ---------------------------------------------------------------------------
module synth_frame_trig_gen
    import synth_frame_trig_gen_pkg::*;
#(
    parameter int unsigned AUDIO_CLK_RATE = DEF_AUDIO_CLK_RATE,
    parameter int unsigned SAMPLE_RATE    = DEF_SAMPLE_RATE,
    parameter int unsigned TRIG_HIGH      = DEF_TRIG_HIGH,
    parameter int unsigned FRAME_CNT_W    = DEF_FRAME_CNT_W,
    parameter int unsigned OVR_CNT_W      = DEF_OVR_CNT_W
) (
    input  logic                   AUDIO_CLK,
    input  logic                   reset_reg_N,
    input  logic                   enable,
    input  logic                   run,
    input  logic                   overrun_clr,
    output logic                   trig,
    output logic                   frame_strobe,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun,
    output logic [OVR_CNT_W-1:0]   overrun_cnt
);

    localparam int STRETCH_W = utils::clogb2(TRIG_HIGH) + 1;
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(TRIG_HIGH - 1);

    // Bad rate/width combinations would silently break the stretch FSM or the
    // synchroniser capture, so refuse to elaborate.
    if (!(SAMPLE_RATE < AUDIO_CLK_RATE / 4)) begin : g_rate_chk
        $error("synth_frame_trig_gen: SAMPLE_RATE must be < AUDIO_CLK_RATE/4");
    end
    if (TRIG_HIGH < 1 || TRIG_HIGH > (AUDIO_CLK_RATE / SAMPLE_RATE) / 2) begin : g_high_chk
        $error("synth_frame_trig_gen: TRIG_HIGH must be 1..(AUDIO_CLK_RATE/SAMPLE_RATE)/2");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } stretch_state_e;

    stretch_state_e         state_q, state_d;
    logic [STRETCH_W-1:0]   stretchCnt_q, stretchCnt_d;
    logic                   strobe_q, strobe_d;
    logic [FRAME_CNT_W-1:0] frameCnt_q, frameCnt_d;
    logic                   overrun_q, overrun_d;
    logic [OVR_CNT_W-1:0]   ovrCnt_q, ovrCnt_d;
    logic                   tick;

    frac_rate_div #(
        .MOD (AUDIO_CLK_RATE),
        .INC (SAMPLE_RATE)
    ) u_div (
        .AUDIO_CLK   (AUDIO_CLK),
        .reset_reg_N (reset_reg_N),
        .enable_i    (enable),
        .tick_o      (tick)
    );

    function automatic logic [OVR_CNT_W-1:0] satInc(input logic [OVR_CNT_W-1:0] v);
        return (&v) ? v : v + OVR_CNT_W'(1);
    endfunction

    // Stretch FSM: a tick loads the down-counter and holds trig high until
    // it reaches zero. Disabling truncates a pulse in flight.
    always_comb begin
        state_d      = state_q;
        stretchCnt_d = stretchCnt_q;
        if (!enable) begin
            state_d      = ST_IDLE;
            stretchCnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_d      = ST_HIGH;
                        stretchCnt_d = STRETCH_LOAD;
                    end
                end
                ST_HIGH: begin
                    if (stretchCnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        stretchCnt_d = stretchCnt_q - STRETCH_W'(1);
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    stretchCnt_d = '0;
                end
            endcase
        end
    end

    // Frame strobe and frame counter follow the tick directly; disable zeroes
    // the counter so it counts frames since the last enable rise.
    always_comb begin
        strobe_d   = 1'b0;
        frameCnt_d = frameCnt_q;
        if (!enable) begin
            frameCnt_d = '0;
        end else if (tick) begin
            strobe_d   = 1'b1;
            frameCnt_d = frameCnt_q + FRAME_CNT_W'(1);
        end
    end

    // Overrun tracking is independent of enable. A clear coinciding with a
    // new overrun still records that overrun, so the count restarts at 1.
    always_comb begin
        overrun_d = overrun_q;
        ovrCnt_d  = ovrCnt_q;
        if (tick && run) begin
            overrun_d = 1'b1;
            ovrCnt_d  = overrun_clr ? OVR_CNT_W'(1) : satInc(ovrCnt_q);
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
            ovrCnt_d  = '0;
        end
    end

    // All state registers.
    always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q      <= ST_IDLE;
            stretchCnt_q <= '0;
            strobe_q     <= 1'b0;
            frameCnt_q   <= '0;
            overrun_q    <= 1'b0;
            ovrCnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            stretchCnt_q <= stretchCnt_d;
            strobe_q     <= strobe_d;
            frameCnt_q   <= frameCnt_d;
            overrun_q    <= overrun_d;
            ovrCnt_q     <= ovrCnt_d;
        end
    end

    // The period is at least twice TRIG_HIGH, so a tick can never land while
    // a pulse is still being stretched.
    assert property (@(posedge AUDIO_CLK) disable iff (!reset_reg_N)
                     !(tick && (state_q == ST_HIGH)));

    assign trig         = (state_q == ST_HIGH);
    assign frame_strobe = strobe_q;
    assign frame_cnt    = frameCnt_q;
    assign overrun      = overrun_q;
    assign overrun_cnt  = ovrCnt_q;

endmodule

// File: tb/tb_synth_frame_trig_gen.sv
// ---------------------------------------------------------------------------
// tb_synth_frame_trig_gen
//
// Small-rate configuration (MOD=32, INC=7, TRIG_HIGH=2, 4-bit frame counter,
// 2-bit overrun counter) so every corner is reachable in a few thousand
// cycles. Ticks from acc=0 land on enabled edges 5,10,14,19,23,28,32.
// ---------------------------------------------------------------------------
module tb_synth_frame_trig_gen;

    localparam int MOD = 32;
    localparam int INC = 7;
    localparam int TH  = 2;
    localparam int FW  = 4;
    localparam int OW  = 2;

    logic          AUDIO_CLK;
    logic          reset_reg_N;
    logic          enable;
    logic          run;
    logic          overrun_clr;
    logic          trig;
    logic          frame_strobe;
    logic [FW-1:0] frame_cnt;
    logic          overrun;
    logic [OW-1:0] overrun_cnt;

    int errors = 0;
    int checks = 0;

    synth_frame_trig_gen #(
        .AUDIO_CLK_RATE (MOD),
        .SAMPLE_RATE    (INC),
        .TRIG_HIGH      (TH),
        .FRAME_CNT_W    (FW),
        .OVR_CNT_W      (OW)
    ) dut (
        .AUDIO_CLK    (AUDIO_CLK),
        .reset_reg_N  (reset_reg_N),
        .enable       (enable),
        .run          (run),
        .overrun_clr  (overrun_clr),
        .trig         (trig),
        .frame_strobe (frame_strobe),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun),
        .overrun_cnt  (overrun_cnt)
    );

    initial AUDIO_CLK = 1'b0;
    always #5 AUDIO_CLK = ~AUDIO_CLK;

    // Reference model state: pulse length expressed as "cycles of trig left".
    int mAcc, mLeft, mFrame, mOvrCnt;
    logic mStrobe, mOvr;

    typedef struct {
        logic trig;
        logic strobe;
        int   frameCnt;
        logic ovr;
        int   ovrCnt;
    } exp_t;
    exp_t expQ[$];

    typedef struct {
        logic en;
        logic run;
        logic clr;
        int   cycles;
        int   expStrobes;
        int   expFrameCnt;
        logic expOvr;
        int   expOvrCnt;
    } vec_t;
    vec_t vecs[9];

    task automatic modelReset();
        mAcc = 0; mLeft = 0; mFrame = 0; mOvrCnt = 0; mStrobe = 1'b0; mOvr = 1'b0;
        expQ.delete();
    endtask

    task automatic modelStep(input logic en, input logic runV, input logic clr);
        exp_t e;
        logic tk;
        tk = 1'b0;
        if (!en) begin
            mAcc = 0; mLeft = 0; mFrame = 0; mStrobe = 1'b0;
        end else begin
            mAcc = mAcc + INC;
            if (mAcc >= MOD) begin
                mAcc = mAcc - MOD;
                tk = 1'b1;
            end
            mStrobe = tk;
            if (tk) begin
                mFrame = (mFrame + 1) % (1 << FW);
                mLeft  = TH;
            end else if (mLeft > 0) begin
                mLeft = mLeft - 1;
            end
        end
        if (tk && runV) begin
            mOvr    = 1'b1;
            mOvrCnt = clr ? 1 : ((mOvrCnt < (1 << OW) - 1) ? mOvrCnt + 1 : mOvrCnt);
        end else if (clr) begin
            mOvr = 1'b0; mOvrCnt = 0;
        end
        e.trig = (mLeft > 0); e.strobe = mStrobe; e.frameCnt = mFrame;
        e.ovr = mOvr; e.ovrCnt = mOvrCnt;
        expQ.push_back(e);
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Pops the scoreboard entry for the edge just taken and compares all outputs.
    task automatic checkOutput();
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: no expected entry at %0t", $time);
            return;
        end
        e = expQ.pop_front();
        if (trig !== e.trig || frame_strobe !== e.strobe || frame_cnt !== FW'(e.frameCnt)
            || overrun !== e.ovr || overrun_cnt !== OW'(e.ovrCnt)) begin
            errors++;
            $display("[TB] FAIL cycle@%0t: got trig=%b strobe=%b fcnt=%0d ovr=%b ocnt=%0d, expected trig=%b strobe=%b fcnt=%0d ovr=%b ocnt=%0d",
                     $time, trig, frame_strobe, frame_cnt, overrun, overrun_cnt,
                     e.trig, e.strobe, e.frameCnt, e.ovr, e.ovrCnt);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic runV, input logic clr);
        enable = en; run = runV; overrun_clr = clr;
        modelStep(en, runV, clr);
        @(posedge AUDIO_CLK);
        #1;
        checkOutput();
    endtask

    initial begin
        int strobes, firstEdge, lastEdge, minGap, maxGap, frames, runLeft, steps;
        logic prevTrig, runV;

        vecs[0] = '{1'b0, 1'b0, 1'b0,  3,  0,  0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32,  7,  7, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 64, 14,  5, 1'b0, 0};  // frame_cnt wraps
        vecs[3] = '{1'b1, 1'b1, 1'b0, 14,  3,  8, 1'b1, 3};  // 3 overruns
        vecs[4] = '{1'b1, 1'b0, 1'b1,  1,  0,  8, 1'b0, 0};  // clear, no tick
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32,  7, 15, 1'b1, 3};  // 7 overruns saturate
        vecs[6] = '{1'b0, 1'b0, 1'b0,  2,  0,  0, 1'b1, 3};  // overrun untouched
        vecs[7] = '{1'b1, 1'b0, 1'b0,  4,  0,  0, 1'b1, 3};  // latency: no tick yet
        vecs[8] = '{1'b1, 1'b0, 1'b0,  1,  1,  1, 1'b1, 3};  // 5th enabled edge

        reset_reg_N = 1'b0; enable = 1'b0; run = 1'b0; overrun_clr = 1'b0;
        modelReset();
        #12;
        checkVal("reset trig", int'(trig), 0);
        checkVal("reset strobe", int'(frame_strobe), 0);
        checkVal("reset frame_cnt", int'(frame_cnt), 0);
        checkVal("reset overrun", int'(overrun), 0);
        checkVal("reset overrun_cnt", int'(overrun_cnt), 0);
        reset_reg_N = 1'b1;

        for (int r = 0; r < 9; r++) begin
            strobes = 0;
            for (int c = 0; c < vecs[r].cycles; c++) begin
                applyStimulus(vecs[r].en, vecs[r].run, vecs[r].clr);
                if (frame_strobe) strobes++;
            end
            checkVal($sformatf("row%0d strobes", r), strobes, vecs[r].expStrobes);
            checkVal($sformatf("row%0d frame_cnt", r), int'(frame_cnt), vecs[r].expFrameCnt);
            checkVal($sformatf("row%0d overrun", r), int'(overrun), int'(vecs[r].expOvr));
            checkVal($sformatf("row%0d overrun_cnt", r), int'(overrun_cnt), vecs[r].expOvrCnt);
        end

        // Set-wins: acc=3, four quiet edges then the tick edge with clear asserted.
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkVal("setwins strobe", int'(frame_strobe), 1);
        checkVal("setwins overrun", int'(overrun), 1);
        checkVal("setwins overrun_cnt", int'(overrun_cnt), 1);

        // Disable while trig is high: pulse truncated on the very next edge.
        checkVal("pre-disable trig", int'(trig), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkVal("disable trig", int'(trig), 0);
        checkVal("disable frame_cnt", int'(frame_cnt), 0);
        checkVal("disable keeps overrun_cnt", int'(overrun_cnt), 1);

        // Re-enable: accumulator restarted at 0, first strobe on edge ceil(32/7)=5.
        firstEdge = 0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (frame_strobe && firstEdge == 0) firstEdge = i;
        end
        checkVal("reenable first strobe edge", firstEdge, 5);

        // Long-term rate: 3200 enabled cycles = 100 full periods -> 700 frames.
        strobes = 0; lastEdge = -1; minGap = 1000; maxGap = 0;
        for (int i = 0; i < 3200; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (frame_strobe) begin
                strobes++;
                if (lastEdge >= 0) begin
                    if (i - lastEdge < minGap) minGap = i - lastEdge;
                    if (i - lastEdge > maxGap) maxGap = i - lastEdge;
                end
                lastEdge = i;
            end
        end
        checkVal("longterm strobes", strobes, 700);
        checkVal("longterm min gap", minGap, 4);
        checkVal("longterm max gap", maxGap, 5);

        // Async reset in the middle of a pulse clears outputs without a clock edge.
        steps = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            steps++;
        end while (!frame_strobe && steps < 10);
        checkVal("strobe before async reset", int'(frame_strobe), 1);
        #3;
        reset_reg_N = 1'b0;
        #1;
        checkVal("async reset trig", int'(trig), 0);
        checkVal("async reset strobe", int'(frame_strobe), 0);
        checkVal("async reset frame_cnt", int'(frame_cnt), 0);
        checkVal("async reset overrun", int'(overrun), 0);
        checkVal("async reset overrun_cnt", int'(overrun_cnt), 0);
        modelReset();
        #2;
        reset_reg_N = 1'b1;

        // Downstream frame model: run goes high for two cycles after each trig
        // rise and is always finished before the next frame is due.
        frames = 0; runLeft = 0; prevTrig = 1'b0; steps = 0;
        while (frames < 100 && steps < 1000) begin
            runV = (runLeft > 0);
            if (runLeft > 0) runLeft--;
            applyStimulus(1'b1, runV, 1'b0);
            if (trig && !prevTrig) begin
                frames++;
                runLeft = 2;
            end
            prevTrig = trig;
            steps++;
        end
        checkVal("integration frames", frames, 100);
        checkVal("integration overrun", int'(overrun), 0);
        checkVal("integration overrun_cnt", int'(overrun_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
